opt_check_monitor: RTL

Synthesizable self-checking response monitor for the small optimization test cells (`opt_check`-style two-input logic). It is the receiving end of the stimulus pattern: it observes the cell's inputs `a`, `b` and its output `y` every clock, compares `y` against the golden function, and accumulates errors and input-combination coverage. At the end of a fixed-length window it reports a pass/fail verdict, so the logic-optimization checks can run self-checked in gate-level simulation and on silicon.

---
 rtl/opt_check_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/opt_check_monitor.sv | 105 ++++++++++
 3 files changed

// File: rtl/opt_check_pkg.sv
// rtl/opt_check_pkg.sv - shared types and golden function for the opt_check response monitor
package opt_check_pkg;

  localparam int FUNC_AND = 0;
  localparam int FUNC_OR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Any code other than AND falls back to OR.
  function automatic logic exp_y(input int func, input logic a, input logic b);
    return (func == FUNC_AND) ? (a & b) : (a | b);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that sticks at all-ones, with clear and enable
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/opt_check_monitor.sv
// rtl/opt_check_monitor.sv - windowed compare of an observed two-input cell against its golden function
module opt_check_monitor
  import opt_check_pkg::*;
#(
  parameter int FUNC       = 1,
  parameter int SAMPLE_LEN = 300,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_vec
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_LEN - 1);

  state_t     state;
  logic       sampling;
  logic       mismatch;
  logic       restart;
  logic [3:0] cov_next;

  always_comb begin
    sampling = (state == ST_RUN) && !abort;
    mismatch = sampling && (y != exp_y(FUNC, a, b));
    restart  = start && (state != ST_RUN);
    cov_next = cov | (4'b0001 << {a, b});
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .en      (mismatch),
    .count   (err_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      sample_cnt    <= '0;
      cov           <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            sample_cnt    <= '0;
            cov           <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            cov        <= cov_next;
            // err_cnt never returns to zero inside a window, so zero marks the first miss.
            if (mismatch && (err_cnt == '0)) begin
              first_err_idx <= sample_cnt;
              first_err_vec <= {a, b, y};
            end
            if (sample_cnt == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_cnt == '0) && (cov_next == 4'b1111);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule
